// File: rtl/alu_div_if.sv
// rtl/alu_div_if.sv - function encoding and execute-stage bus for the HI/LO divider
package alu_div_pkg;
    typedef enum logic [2:0] {
        FUNC_NONE = 3'd0,
        FUNC_DIV  = 3'd1,
        FUNC_DIVU = 3'd2,
        FUNC_MFHI = 3'd3,
        FUNC_MFLO = 3'd4,
        FUNC_MTHI = 3'd5,
        FUNC_MTLO = 3'd6
    } alu_func_t;
endpackage

interface alu_div_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    import alu_div_pkg::*;

    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    alu_func_t          func;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  result;
    logic               zero;
    logic               stall;

    modport master (
        output data1, data2, func, shamt,
        input  result, zero, stall
    );

    modport slave (
        input  data1, data2, func, shamt,
        output result, zero, stall
    );
endinterface

// File: rtl/alu_div.sv
// rtl/alu_div.sv - radix-2 restoring DIV/DIVU with its own HI/LO pair and MFHI/MFLO/MTHI/MTLO
// Stalls the pipeline for DATA_W+2 cycles per divide; retires in the DONE cycle.
module alu_div
    import alu_div_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic   clk_i,
    input  logic   rst_i,
    alu_div_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               dz_q, dz_d;

    logic               is_div;
    logic               stall;
    logic [DATA_W:0]    shifted;
    logic [DATA_W:0]    trial;
    logic [DATA_W-1:0]  result;
    logic               unused_shamt;

    assign unused_shamt = ^bus.shamt;
    assign is_div       = (bus.func == FUNC_DIV) || (bus.func == FUNC_DIVU);
    assign shifted      = {rem_q, quo_q[DATA_W-1]};
    assign trial        = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        stall   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_div) begin
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    dz_d    = (bus.data2 == '0);
                    if (bus.func == FUNC_DIV) begin
                        // Magnitudes are taken as unsigned W-bit values so MIN/-1 needs no special case
                        quo_d   = bus.data1[DATA_W-1] ? -bus.data1 : bus.data1;
                        dvs_d   = bus.data2[DATA_W-1] ? -bus.data2 : bus.data2;
                        qsign_d = bus.data1[DATA_W-1] ^ bus.data2[DATA_W-1];
                        rsign_d = bus.data1[DATA_W-1];
                    end else begin
                        quo_d   = bus.data1;
                        dvs_d   = bus.data2;
                        qsign_d = 1'b0;
                        rsign_d = 1'b0;
                    end
                end else if (bus.func == FUNC_MTHI) begin
                    hi_d = bus.data1;
                end else if (bus.func == FUNC_MTLO) begin
                    lo_d = bus.data1;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                rem_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                stall   = 1'b1;
                state_d = ST_DONE;
                // Operands are held stable by the stall, so data1 is still the dividend here
                if (dz_q) begin
                    lo_d = '1;
                    hi_d = bus.data1;
                end else begin
                    lo_d = qsign_q ? -quo_q : quo_q;
                    hi_d = rsign_q ? -rem_q : rem_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        result = '0;
        case (bus.func)
            FUNC_MFHI: result = hi_q;
            FUNC_MFLO: result = lo_q;
            default:   result = '0;
        endcase
    end

    assign bus.result = result;
    assign bus.zero   = (result == '0);
    assign bus.stall  = stall;
endmodule

// File: doc/alu_div.md
Name: alu_div

Overview:
- Multi-cycle iterative divider for the execute stage. It is the inverse-direction companion of the HI/LO multiply path.
- Executes MIPS DIV/DIVU: the quotient is written to LO and the remainder to HI. It also serves MFHI/MFLO/MTHI/MTLO on its own HI/LO pair.
- Asserts stall to freeze the pipeline while a division is in flight.
- Radix-2 restoring algorithm: one quotient bit per cycle, with sign pre/post-correction for signed operation.

Parameters:
- DATA_W, 32, operand/result width; bench uses 4.
- SHAMT_W, 5, shamt width; accepted for port compatibility, unused.

Ports:
- ctrl  input  Util_Control_T bundle  carries clock and reset; the clock is the single rising-edge clock; reset is asynchronous, active-high.
- data1  input  DATA_W  dividend / MTHI-MTLO source.
- data2  input  DATA_W  divisor.
- func  input  Alu_Func_T  operation: Div, Divu, Mfhi, Mflo, Mthi, Mtlo; all others are treated as None.
- shamt  input  SHAMT_W  ignored.
- result  output  DATA_W  read data for Mfhi/Mflo, else 0.
- zero  output  1  result == 0.
- stall  output  1  high = hold pipeline; func/data must stay stable.

Behaviour:
- Reset (async, any state): state=IDLE; hi=lo=0; counter=0; stall=0; result=0 for func None; zero=1.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - func Div/Divu: stall=1 combinationally that cycle. On the edge, latch operands and go to BUSY.
    - Signed: |data1|, |data2| as DATA_W-bit unsigned; latch qsign=s1^s2 and rsign=s1.
    - Unsigned: raw operands, signs=0.
    - Remainder accumulator=0; counter=DATA_W-1.
  - func Mthi/Mtlo: hi/lo <= data1 on the edge; stall=0.
  - func Mfhi/Mflo: result=hi/lo combinationally; stall=0.
- BUSY:
  - Each cycle, shift {rem,quo} left 1; trial-subtract divisor from rem; if no borrow keep the difference and set the quo LSB.
  - counter decrements; when counter==0, next state FIX. BUSY lasts exactly DATA_W cycles; stall=1.
- FIX:
  - lo <= qsign ? -quo : quo; hi <= rsign ? -rem : rem.
  - stall=1; next state DONE.
- DONE:
  - stall=0; the still-present Div func is the same instruction and must NOT restart.
  - result follows Mfhi/Mflo rules; next state IDLE unconditionally.
- Total stall per divide: DATA_W+2 cycles (IDLE detect + DATA_W BUSY + FIX). The instruction retires in the DONE cycle.
- Mfhi/Mflo/Mthi/Mtlo while BUSY/FIX: cannot occur because the pipeline is frozen. hi/lo are not writable outside IDLE.
- Divide by zero, signed or unsigned: no trap; lo=all ones, hi=dividend. This falls out of the algorithm for unsigned. Signed: force lo=all ones, hi=data1 in FIX.
- Signed overflow (most negative / -1): lo=most negative, hi=0. This falls out of W-bit magnitudes and needs no special case.
- Arithmetic is modulo 2^DATA_W; the accumulator is DATA_W+1 bits for borrow detection.
- Reset asserted mid-divide: immediate IDLE, hi=lo=0, stall drops without waiting for a clock edge; the partial result is discarded.
- result/zero are combinational from func and hi/lo; they are 0/1 for every non-Mf func, including Div.

Test Plan:
- DATA_W=4 Divu 7/2, then Mflo, Mfhi -> stall high exactly 6 cycles; Mflo result=4'h3, Mfhi result=4'h1, zero=0.
- Div 4'h9 (-7) / 4'h2 -> lo=4'hD (-3), hi=4'hF (-1). Then Div 4'h7 / 4'hE (-2) -> lo=4'hD, hi=4'h1.
- Divu 4'h5/4'h0 and Div 4'hB/4'h0 -> lo=4'hF, hi=4'h5 and 4'hB respectively; no X on any output.
- Div 4'h8 / 4'hF -> lo=4'h8, hi=4'h0. Follow with Mthi 4'hA, Mtlo 4'h0, Mfhi (result 4'hA), Mflo (result 0, zero=1); stall=0 throughout the moves.
- Back-to-back Divu 4'hF/4'h1 then Divu 4'hE/4'h3 with func held during stall -> two separate 6-cycle stall windows; one DONE cycle between them with stall=0; final lo=4'h4, hi=4'h2.
- Assert reset 2 cycles into BUSY for Divu 4'hF/4'h1 -> stall=0 and hi=lo=0 before the next clock edge; after release, Mflo=0 and a new Divu 4'h9/4'h3 gives lo=4'h3, hi=0.
